// File: rtl/breakout_pkg.sv
// rtl/breakout_pkg.sv - shared constants and types for the breakout link
package breakout_pkg;

   localparam int FRAME_BITS = 12;

   typedef logic [2:0] pair_cnt_t;

   localparam pair_cnt_t PAIRS_PER_FRAME = 3'd6;
   localparam pair_cnt_t PAIR_CNT_MAX    = 3'd7;
   localparam pair_cnt_t MARK_CYCLES     = 3'd3;

   localparam logic [3:0] ADDR_DOUT = 4'h1;
   localparam logic [3:0] ADDR_LED  = 4'h2;

   typedef struct packed {
      logic [3:0] addr;
      logic [7:0] data;
   } link_word_t;

endpackage

// File: rtl/breakout_deser.sv
// rtl/breakout_deser.sv - frame detect, DDR capture and word assembly for the downstream lane
module breakout_deser #(
   parameter int FRAME_BITS   = breakout_pkg::FRAME_BITS,
   parameter int BITS_PER_CLK = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  frame_clk,
   input  logic                  sdata,
   output logic                  frame_start,
   output logic [FRAME_BITS-1:0] word_tdata,
   output logic                  word_tvalid
);
   import breakout_pkg::*;

   logic                    fclk_q;
   logic                    fclk_qq;
   logic                    ddr_rise;
   logic                    ddr_fall;
   logic                    synced;
   logic [BITS_PER_CLK-1:0] pair;
   logic [FRAME_BITS-1:0]   shift_q;
   pair_cnt_t               pair_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         fclk_q   <= 1'b0;
         fclk_qq  <= 1'b0;
         ddr_rise <= 1'b0;
      end else begin
         fclk_q   <= frame_clk;
         fclk_qq  <= fclk_q;
         ddr_rise <= sdata;
      end
   end

   // The falling-edge bit completes the pair that the next rising edge consumes.
   always_ff @(negedge clk) begin
      if (rst) begin
         ddr_fall <= 1'b0;
      end else begin
         ddr_fall <= sdata;
      end
   end

   assign frame_start = fclk_q & ~fclk_qq;
   assign pair        = {ddr_rise, ddr_fall};

   always_ff @(posedge clk) begin
      if (rst) begin
         shift_q  <= '0;
         pair_cnt <= '0;
         synced   <= 1'b0;
      end else begin
         shift_q <= {shift_q[FRAME_BITS-BITS_PER_CLK-1:0], pair};
         if (frame_start) begin
            pair_cnt <= 3'd1;
            synced   <= 1'b1;
         end else if (pair_cnt != PAIR_CNT_MAX) begin
            pair_cnt <= pair_cnt + 3'd1;
         end
      end
   end

   // Words before the first seen frame start have no trustworthy boundary.
   assign word_tvalid = frame_start & synced & (pair_cnt == PAIRS_PER_FRAME);
   assign word_tdata  = shift_q;

endmodule

// File: rtl/breakout.sv
// rtl/breakout.sv - LVDS breakout: downstream command decode and upstream input serialiser
module breakout #(
   parameter int FRAME_BITS   = breakout_pkg::FRAME_BITS,
   parameter int BITS_PER_CLK = 2
) (
   input  logic       PLL_SIM,
   input  logic       RESET,
   input  logic       XTAL,
   input  logic       D_IN0,
   input  logic       D_IN1,
   input  logic       D_IN2,
   input  logic       D_IN3,
   input  logic       D_IN4,
   input  logic       D_IN5,
   input  logic       D_IN6,
   input  logic       D_IN7,
   input  logic [1:0] LVDS_IN,
   output logic [7:0] D_OUT,
   output logic [2:0] LVDS_OUT,
   inout  tri         I2C_SCL,
   inout  tri         I2C_SDA,
   output logic       HARP_CLK_OUT,
   output logic       LED,
   output logic       USBPU,
   output logic       NEOPIX,
   output logic       UART
);
   import breakout_pkg::*;

   localparam int HALF = FRAME_BITS / 2;

   logic                  frame_start;
   logic                  word_tvalid;
   logic [FRAME_BITS-1:0] word_tdata;
   link_word_t            cmd;
   logic [7:0]            din_raw;
   logic [7:0]            din_meta;
   logic [7:0]            din;
   logic [3:0]            fcnt;
   logic [FRAME_BITS-1:0] up_word;
   logic [HALF-1:0]       hi_sr;
   logic [HALF-1:0]       lo_sr;
   pair_cnt_t             up_phase;
   logic                  unused_xtal;

   breakout_deser #(
      .FRAME_BITS   (FRAME_BITS),
      .BITS_PER_CLK (BITS_PER_CLK)
   ) u_deser (
      .clk         (PLL_SIM),
      .rst         (RESET),
      .frame_clk   (LVDS_IN[0]),
      .sdata       (LVDS_IN[1]),
      .frame_start (frame_start),
      .word_tdata  (word_tdata),
      .word_tvalid (word_tvalid)
   );

   assign cmd = word_tdata;

   always_ff @(posedge PLL_SIM) begin
      if (RESET) begin
         D_OUT <= 8'h00;
         LED   <= 1'b0;
      end else if (word_tvalid) begin
         case (cmd.addr)
            ADDR_DOUT: D_OUT <= cmd.data;
            ADDR_LED:  LED   <= cmd.data[0];
            default:   ;
         endcase
      end
   end

   assign din_raw = {D_IN7, D_IN6, D_IN5, D_IN4, D_IN3, D_IN2, D_IN1, D_IN0};

   always_ff @(posedge PLL_SIM) begin
      if (RESET) begin
         din_meta <= 8'h00;
         din      <= 8'h00;
      end else begin
         din_meta <= din_raw;
         din      <= din_meta;
      end
   end

   assign up_word = {fcnt, din};

   // Phase stops at PAIRS_PER_FRAME; by then both lanes have shifted out to zero.
   always_ff @(posedge PLL_SIM) begin
      if (RESET) begin
         fcnt     <= 4'd0;
         hi_sr    <= '0;
         lo_sr    <= '0;
         up_phase <= PAIRS_PER_FRAME;
      end else if (frame_start) begin
         fcnt     <= fcnt + 4'd1;
         hi_sr    <= up_word[FRAME_BITS-1:HALF];
         lo_sr    <= up_word[HALF-1:0];
         up_phase <= '0;
      end else begin
         hi_sr <= {hi_sr[HALF-2:0], 1'b0};
         lo_sr <= {lo_sr[HALF-2:0], 1'b0};
         if (up_phase != PAIRS_PER_FRAME) begin
            up_phase <= up_phase + 3'd1;
         end
      end
   end

   assign LVDS_OUT = {lo_sr[HALF-1], hi_sr[HALF-1], (up_phase < MARK_CYCLES)};

   assign I2C_SCL      = 1'bz;
   assign I2C_SDA      = 1'bz;
   assign HARP_CLK_OUT = 1'b0;
   assign USBPU        = 1'b0;
   assign NEOPIX       = 1'b0;
   assign UART         = 1'b1;

   // XTAL feeds only the hardware PLL.
   assign unused_xtal = XTAL;

endmodule

// File: tb/tb_breakout.sv
// tb/tb_breakout.sv - bench for breakout: frame-level model plus directed vectors
module tb_breakout;

   logic       PLL_SIM = 1'b0;
   logic       RESET   = 1'b1;
   logic       XTAL    = 1'b0;
   logic [7:0] d_in    = 8'h5A;
   logic [1:0] lvds_in = 2'b00;
   wire  [7:0] D_OUT;
   wire  [2:0] LVDS_OUT;
   wire        scl;
   wire        sda;
   wire        harp;
   wire        led;
   wire        usbpu;
   wire        neopix;
   wire        uart;

   int errors = 0;
   int checks = 0;
   int nfr    = 0;
   bit chk_en = 1'b0;
   logic [11:0] h0 = '0;
   logic [11:0] h1 = '0;
   logic [11:0] h2 = '0;

   always #8  PLL_SIM = ~PLL_SIM;
   always #31 XTAL    = ~XTAL;

   breakout dut (
      .PLL_SIM      (PLL_SIM),
      .RESET        (RESET),
      .XTAL         (XTAL),
      .D_IN0        (d_in[0]),
      .D_IN1        (d_in[1]),
      .D_IN2        (d_in[2]),
      .D_IN3        (d_in[3]),
      .D_IN4        (d_in[4]),
      .D_IN5        (d_in[5]),
      .D_IN6        (d_in[6]),
      .D_IN7        (d_in[7]),
      .LVDS_IN      (lvds_in),
      .D_OUT        (D_OUT),
      .LVDS_OUT     (LVDS_OUT),
      .I2C_SCL      (scl),
      .I2C_SDA      (sda),
      .HARP_CLK_OUT (harp),
      .LED          (led),
      .USBPU        (usbpu),
      .NEOPIX       (neopix),
      .UART         (uart)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Frame-level model: bits since the last frame start, word effects one cycle after detection.
   bit         m_bits[$];
   bit         m_prev_f = 1'b0;
   bit         m_seen = 1'b0;
   bit         m_pend_commit = 1'b0;
   bit         m_pend_start = 1'b0;
   logic [11:0] m_pend_word = '0;
   logic [11:0] m_up_word = '0;
   logic [3:0]  m_fcnt = '0;
   int          m_k = 6;
   logic [7:0]  exp_dout = '0;
   logic        exp_led = 1'b0;

   always @(posedge PLL_SIM or negedge PLL_SIM) begin
      if (!PLL_SIM) begin
         m_bits.push_back(lvds_in[1]);
      end else if (RESET) begin
         exp_dout = 8'h00;
         exp_led = 1'b0;
         m_k = 6;
         m_fcnt = 4'd0;
         m_up_word = '0;
         m_seen = 1'b0;
         m_bits.delete();
         m_prev_f = 1'b0;
         m_pend_commit = 1'b0;
         m_pend_start = 1'b0;
      end else begin
         if (m_pend_commit) begin
            if (m_pend_word[11:8] == 4'h1) exp_dout = m_pend_word[7:0];
            else if (m_pend_word[11:8] == 4'h2) exp_led = m_pend_word[0];
         end
         if (m_pend_start) begin
            m_up_word = {m_fcnt, d_in};
            m_fcnt = m_fcnt + 4'd1;
            m_k = 0;
         end else if (m_k < 6) begin
            m_k++;
         end
         m_pend_commit = 1'b0;
         m_pend_start = 1'b0;
         if (lvds_in[0] && !m_prev_f) begin
            if (m_seen && m_bits.size() == 12) begin
               m_pend_commit = 1'b1;
               for (int i = 0; i < 12; i++) m_pend_word[11-i] = m_bits[i];
            end
            m_seen = 1'b1;
            m_bits.delete();
            m_pend_start = 1'b1;
         end
         m_prev_f = lvds_in[0];
         m_bits.push_back(lvds_in[1]);
      end
   end

   function automatic logic [2:0] exp_lvds();
      if (m_k > 5) return 3'b000;
      return {m_up_word[5-m_k], m_up_word[11-m_k], (m_k < 3)};
   endfunction

   always @(negedge PLL_SIM) begin
      if (chk_en) begin
         check("d_out", 32'(D_OUT), 32'(exp_dout));
         check("led", 32'(led), 32'(exp_led));
         check("lvds_out", 32'(LVDS_OUT), 32'(exp_lvds()));
         check("const_outs", 32'({harp, usbpu, neopix, uart}), 32'(4'b0001));
      end
   end

   task automatic drive_cycle(input bit f, input bit hi, input bit lo);
      @(negedge PLL_SIM);
      #4;
      lvds_in = {hi, f};
      @(posedge PLL_SIM);
      #4;
      lvds_in[1] = lo;
      h0 = {h0[10:0], LVDS_OUT[0]};
      h1 = {h1[10:0], LVDS_OUT[1]};
      h2 = {h2[10:0], LVDS_OUT[2]};
   endtask

   task automatic drive_frame(input logic [11:0] word, input int npairs);
      for (int j = 0; j < npairs; j++) begin
         drive_cycle(j < 3, word[11-2*j], word[10-2*j]);
      end
      nfr++;
   endtask

   // History bits [10:5] hold the previous frame's six upstream cycles, oldest first.
   task automatic check_upstream();
      logic [3:0] fexp;
      if (nfr >= 2) begin
         fexp = 4'((nfr - 2) % 16);
         check("up_marker", 32'(h0[10:5]), 32'(6'b111000));
         check("up_lane1", 32'(h1[10:5]), 32'({fexp, 2'b01}));
         check("up_lane2", 32'(h2[10:5]), 32'(6'b011010));
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish, want finish");
      $fatal(1);
   end

   initial begin
      repeat (3) drive_cycle(1'b0, 1'b0, 1'b0);
      check("rst_dout", 32'(D_OUT), 32'h00);
      check("rst_led", 32'(led), 32'h0);
      check("rst_lvds", 32'(LVDS_OUT), 32'h0);
      chk_en = 1'b1;
      RESET = 1'b0;
      nfr = 0;
      repeat (2) drive_cycle(1'b0, 1'b0, 1'b0);

      drive_frame(12'h1A5, 6);
      drive_frame(12'h1A5, 6);
      check("a5_dout", 32'(D_OUT), 32'hA5);
      drive_frame(12'h1A5, 6);
      check("a5_led", 32'(led), 32'h0);

      drive_frame(12'h201, 6);
      drive_frame(12'h200, 6);
      check("led_on", 32'(led), 32'h1);
      drive_frame(12'h000, 6);
      check("led_off", 32'(led), 32'h0);
      check("led_dout", 32'(D_OUT), 32'hA5);

      drive_frame(12'hFFF, 6);
      drive_frame(12'h100, 6);
      check("fff_noop", 32'(D_OUT), 32'hA5);
      drive_frame(12'h000, 6);
      check("dout_zero", 32'(D_OUT), 32'h00);

      drive_frame(12'h1A5, 6);
      drive_frame(12'h1C3, 4);
      check("pre_short", 32'(D_OUT), 32'hA5);
      drive_frame(12'h133, 6);
      check("short_drop", 32'(D_OUT), 32'hA5);
      drive_frame(12'h000, 6);
      check("after_short", 32'(D_OUT), 32'h33);

      drive_frame(12'h1A5, 6);
      drive_cycle(1'b1, 1'b0, 1'b0);
      drive_cycle(1'b1, 1'b0, 1'b0);
      check("pre_reset", 32'(D_OUT), 32'hA5);
      RESET = 1'b1;
      nfr = 0;
      drive_cycle(1'b1, 1'b0, 1'b0);
      check("mid_reset_dout", 32'(D_OUT), 32'h00);
      check("mid_reset_lvds", 32'(LVDS_OUT), 32'h0);
      drive_cycle(1'b0, 1'b0, 1'b0);
      RESET = 1'b0;
      repeat (2) drive_cycle(1'b0, 1'b0, 1'b0);
      drive_frame(12'h1A5, 6);
      check("post_rst_hold", 32'(D_OUT), 32'h00);
      drive_frame(12'h000, 6);
      check("post_rst_commit", 32'(D_OUT), 32'hA5);
      check_upstream();

      for (int i = 0; i < 17; i++) begin
         drive_frame(12'h000, 6);
         check_upstream();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
